sensor_read: RTL and testbench

SENSOR_READ -- requirements
Module: sensor_read

---
 rtl/sensor_read_pkg.sv | 29 ++
 rtl/sensor_read_chan.sv | 109 ++++++++++
 rtl/sensor_read.sv | 101 ++++++++++
 tb/tb_sensor_read.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_read_pkg.sv
// Shared constants, types and helpers for the sensor_read block.
// Optional feature macro: SENSOR_READ_GLITCH_CNT_EN (per-channel glitch counters).
package sensor_read_pkg;

  // Legal parameter ranges
  localparam int unsigned N_CH_MIN        = 1;
  localparam int unsigned N_CH_MAX        = 32;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned STABLE_CNT_MIN  = 1;
  localparam int unsigned STABLE_CNT_MAX  = 255;

  // Width of each per-channel glitch counter
  localparam int unsigned GLITCH_CNT_W = 8;

  // Snapshot handshake FSM states
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  // Pull an integer parameter into [lo, hi]
  function automatic int unsigned clamp_u(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/sensor_read_chan.sv
// One sensor channel: synchroniser, persistence filter, edge pulses,
// sticky change flag and (with SENSOR_READ_GLITCH_CNT_EN) a glitch counter.
module sensor_read_chan
  import sensor_read_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_evt_clr,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_sticky
`ifdef SENSOR_READ_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_sticky;

  logic w_s;
  logic w_diff;
  logic w_accept;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_diff   = (w_s != r_out);
  assign w_accept = w_diff && (r_cnt == CNT_W'(STABLE_CNT - 1));

  // Metastability synchroniser: shift raw level through SYNC_STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Persistence filter: accept a new level after STABLE_CNT differing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_out  <= w_s;
        r_cnt  <= '0;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky change flag: an accepted change beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= 1'b1;
    end else if (i_evt_clr) begin
      r_sticky <= 1'b0;
    end
  end

`ifdef SENSOR_READ_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;
  logic                    w_glitch;

  // A glitch is an excursion that returns to out's level before acceptance
  assign w_glitch = !w_diff && (r_cnt != '0);

  // Saturating glitch counter, cleared together with the sticky flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (i_evt_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && !(&r_glitch_cnt)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
    end
  end

  assign o_glitch_cnt = r_glitch_cnt;
`endif

  assign o_out    = r_out;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/sensor_read.sv
// Multi-channel debounced sensor reader with a valid/ready snapshot port.
// Optional feature macro: SENSOR_READ_GLITCH_CNT_EN adds the glitch_cnt output.
module sensor_read
  import sensor_read_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_raw,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] evt_sticky,
  input  logic [N_CH-1:0] evt_clr,
  input  logic            snap_req,
  output logic            snap_valid,
  input  logic            snap_ready,
  output logic [N_CH-1:0] snap_data
`ifdef SENSOR_READ_GLITCH_CNT_EN
  ,
  output logic [N_CH*GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned SYNC_EFF   = clamp_u(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  localparam int unsigned STABLE_EFF = clamp_u(STABLE_CNT, STABLE_CNT_MIN, STABLE_CNT_MAX);
  localparam bit          N_CH_OK    = (N_CH >= N_CH_MIN) && (N_CH <= N_CH_MAX);

  snap_state_t     r_state;
  logic            r_snap_valid;
  logic [N_CH-1:0] r_snap_data;

  // Per-channel filters, fully independent of each other
  generate
    if (N_CH_OK) begin : g_chan_array
      for (genvar i = 0; i < N_CH; i++) begin : g_chan
        sensor_read_chan #(
          .SYNC_STAGES (SYNC_EFF),
          .STABLE_CNT  (STABLE_EFF)
        ) u_chan (
          .clk          (clk),
          .rst_n        (rst_n),
          .i_raw        (in_raw[i]),
          .i_evt_clr    (evt_clr[i]),
          .o_out        (out[i]),
          .o_rise       (rise[i]),
          .o_fall       (fall[i]),
          .o_sticky     (evt_sticky[i])
`ifdef SENSOR_READ_GLITCH_CNT_EN
          ,
          .o_glitch_cnt (glitch_cnt[i*GLITCH_CNT_W +: GLITCH_CNT_W])
`endif
        );
      end
    end else begin : g_bad_n_ch
      assign out        = '0;
      assign rise       = '0;
      assign fall       = '0;
      assign evt_sticky = '0;
`ifdef SENSOR_READ_GLITCH_CNT_EN
      assign glitch_cnt = '0;
`endif
    end
  endgenerate

  // Snapshot FSM: capture out on request, hold until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_snap_valid <= 1'b0;
      r_snap_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snap_req) begin
            r_snap_data  <= out;
            r_snap_valid <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (snap_ready) begin
            r_snap_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_snap_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign snap_valid = r_snap_valid;
  assign snap_data  = r_snap_data;

endmodule

// File: tb/tb_sensor_read.sv
// Self-checking bench for sensor_read (default parameters plus a STABLE_CNT=1 copy).
// Glitch-counter checks are compiled in when SENSOR_READ_GLITCH_CNT_EN is defined.
module tb_sensor_read;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] in_raw, evt_clr, out, rise, fall, evt_sticky, snap_data;
  logic       snap_req, snap_ready, snap_valid;

  logic [7:0] in_raw1, evt_clr1, out1, rise1, fall1, evt_sticky1, snap_data1;
  logic       snap_req1, snap_ready1, snap_valid1;

`ifdef SENSOR_READ_GLITCH_CNT_EN
  logic [63:0] glitch_cnt, glitch_cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  exp_t       exp_q[$];
  exp_t       exp1_q[$];
  logic [7:0] snap_q[$];

  always #5 clk = ~clk;

  sensor_read #(.N_CH(8), .SYNC_STAGES(2), .STABLE_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .out(out), .rise(rise), .fall(fall),
    .evt_sticky(evt_sticky), .evt_clr(evt_clr), .snap_req(snap_req),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_data(snap_data)
`ifdef SENSOR_READ_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  sensor_read #(.N_CH(8), .SYNC_STAGES(2), .STABLE_CNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw1), .out(out1), .rise(rise1), .fall(fall1),
    .evt_sticky(evt_sticky1), .evt_clr(evt_clr1), .snap_req(snap_req1),
    .snap_valid(snap_valid1), .snap_ready(snap_ready1), .snap_data(snap_data1)
`ifdef SENSOR_READ_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", out); end
    n_vec++; if ({rise, fall} !== 16'h0000) begin n_err++; $display("FAIL reset_pulses: got %h want 0000", {rise, fall}); end
    n_vec++; if (evt_sticky !== 8'h00) begin n_err++; $display("FAIL reset_sticky: got %h want 00", evt_sticky); end
    n_vec++; if ({snap_valid, snap_data} !== 9'h000) begin n_err++; $display("FAIL reset_snap: got %h want 000", {snap_valid, snap_data}); end
    n_vec++; if (out1 !== 8'h00) begin n_err++; $display("FAIL reset_out1: got %h want 00", out1); end
`ifdef SENSOR_READ_GLITCH_CNT_EN
    n_vec++; if (glitch_cnt !== 64'h0) begin n_err++; $display("FAIL reset_glitch_cnt: got %h want 0", glitch_cnt); end
`endif
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_rise();
    exp_t e;
    in_raw = 8'h01;
    for (int k = 1; k <= 8; k++)
      exp_q.push_back('{out: (k >= 6) ? 8'h01 : 8'h00, rise: (k == 6) ? 8'h01 : 8'h00, fall: 8'h00});
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = exp_q.pop_front();
      n_vec++; if (out !== e.out) begin n_err++; $display("FAIL rise_out edge %0d: got %h want %h", k, out, e.out); end
      n_vec++; if (rise !== e.rise) begin n_err++; $display("FAIL rise_pulse edge %0d: got %h want %h", k, rise, e.rise); end
      n_vec++; if (fall !== e.fall) begin n_err++; $display("FAIL rise_fall edge %0d: got %h want %h", k, fall, e.fall); end
    end
    n_vec++; if (evt_sticky !== 8'h01) begin n_err++; $display("FAIL rise_sticky: got %h want 01", evt_sticky); end
    evt_clr = 8'hFF;
    tick();
    evt_clr = 8'h00;
    n_vec++; if (evt_sticky !== 8'h00) begin n_err++; $display("FAIL rise_sticky_clr: got %h want 00", evt_sticky); end
  endtask

  task automatic test_glitch();
    logic [7:0] pulses;
    pulses = 8'h00;
    in_raw = 8'h09;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) in_raw = 8'h01;
      pulses = pulses | rise | fall;
      n_vec++; if (out !== 8'h01) begin n_err++; $display("FAIL glitch_out edge %0d: got %h want 01", k, out); end
    end
    n_vec++; if (pulses !== 8'h00) begin n_err++; $display("FAIL glitch_pulses: got %h want 00", pulses); end
    n_vec++; if (evt_sticky !== 8'h00) begin n_err++; $display("FAIL glitch_sticky: got %h want 00", evt_sticky); end
`ifdef SENSOR_READ_GLITCH_CNT_EN
    n_vec++; if (glitch_cnt[31:24] !== 8'd1) begin n_err++; $display("FAIL glitch_cnt3: got %0d want 1", glitch_cnt[31:24]); end
    n_vec++; if (glitch_cnt[7:0] !== 8'd0) begin n_err++; $display("FAIL glitch_cnt0: got %0d want 0", glitch_cnt[7:0]); end
`endif
  endtask

  task automatic test_sticky_clr();
    in_raw = 8'h05;
    repeat (5) tick();
    evt_clr = 8'h04;
    tick();
    evt_clr = 8'h00;
    n_vec++; if (out !== 8'h05) begin n_err++; $display("FAIL clr_race_out: got %h want 05", out); end
    n_vec++; if (rise !== 8'h04) begin n_err++; $display("FAIL clr_race_rise: got %h want 04", rise); end
    n_vec++; if (evt_sticky !== 8'h04) begin n_err++; $display("FAIL clr_race_sticky: got %h want 04", evt_sticky); end
    evt_clr = 8'h04;
    tick();
    evt_clr = 8'h00;
    n_vec++; if (evt_sticky !== 8'h00) begin n_err++; $display("FAIL clr_sticky: got %h want 00", evt_sticky); end
  endtask

  task automatic test_snapshot();
    logic [7:0] e;
    in_raw = 8'hA5;
    repeat (8) tick();
    n_vec++; if (out !== 8'hA5) begin n_err++; $display("FAIL snap_setup_out: got %h want a5", out); end
    snap_q.push_back(8'hA5);
    snap_req = 1'b1;
    in_raw = 8'h00;
    tick();
    snap_req = 1'b0;
    n_vec++; if (snap_valid !== 1'b1) begin n_err++; $display("FAIL snap_valid_rise: got %b want 1", snap_valid); end
    n_vec++; if (snap_data !== snap_q[0]) begin n_err++; $display("FAIL snap_data_cap: got %h want %h", snap_data, snap_q[0]); end
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) snap_req = 1'b1;
      if (k == 3) snap_req = 1'b0;
      tick();
      n_vec++; if (snap_valid !== 1'b1) begin n_err++; $display("FAIL snap_hold_valid cyc %0d: got %b want 1", k, snap_valid); end
      n_vec++; if (snap_data !== snap_q[0]) begin n_err++; $display("FAIL snap_hold_data cyc %0d: got %h want %h", k, snap_data, snap_q[0]); end
    end
    n_vec++; if ({out, fall} !== 16'h00A5) begin n_err++; $display("FAIL snap_live_out: got %h want 00a5", {out, fall}); end
    snap_ready = 1'b1;
    e = snap_q.pop_front();
    n_vec++; if (snap_data !== e) begin n_err++; $display("FAIL snap_handshake_data: got %h want %h", snap_data, e); end
    tick();
    snap_ready = 1'b0;
    n_vec++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL snap_valid_drop: got %b want 0", snap_valid); end
    repeat (3) tick();
    n_vec++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL snap_second_req_ignored: got %b want 0", snap_valid); end
    evt_clr = 8'hFF;
    tick();
    evt_clr = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    in_raw = 8'h3C;
    repeat (8) tick();
    snap_ready = 1'b1;
    snap_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) snap_q.push_back(8'h3C);
      tick();
      if (k % 2 == 0) begin
        e = snap_q.pop_front();
        n_vec++; if (snap_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid cyc %0d: got %b want 1", k, snap_valid); end
        n_vec++; if (snap_data !== e) begin n_err++; $display("FAIL b2b_data cyc %0d: got %h want %h", k, snap_data, e); end
      end else begin
        n_vec++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle cyc %0d: got %b want 0", k, snap_valid); end
      end
    end
    snap_req = 1'b0;
    snap_ready = 1'b0;
    tick();
  endtask

  task automatic test_glitch_sat();
    logic [7:0] pulses;
    pulses = 8'h00;
    for (int g = 0; g < 300; g++) begin
      in_raw[1] = 1'b1;
      tick();
      pulses = pulses | rise | fall;
      in_raw[1] = 1'b0;
      tick();
      pulses = pulses | rise | fall;
    end
    repeat (4) tick();
    n_vec++; if (out !== 8'h3C) begin n_err++; $display("FAIL sat_out: got %h want 3c", out); end
    n_vec++; if (pulses !== 8'h00) begin n_err++; $display("FAIL sat_pulses: got %h want 00", pulses); end
`ifdef SENSOR_READ_GLITCH_CNT_EN
    n_vec++; if (glitch_cnt[15:8] !== 8'd255) begin n_err++; $display("FAIL sat_glitch_cnt1: got %0d want 255", glitch_cnt[15:8]); end
    evt_clr = 8'h02;
    tick();
    evt_clr = 8'h00;
    n_vec++; if (glitch_cnt[15:8] !== 8'd0) begin n_err++; $display("FAIL sat_glitch_clr: got %0d want 0", glitch_cnt[15:8]); end
`endif
  endtask

  task automatic test_reset_mid();
    in_raw = 8'hC3;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    repeat (2) tick();
    n_vec++; if ({snap_valid, snap_data} !== 9'h13C) begin n_err++; $display("FAIL midrst_pre_snap: got %h want 13c", {snap_valid, snap_data}); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({out, rise, fall, evt_sticky} !== 32'h0) begin n_err++; $display("FAIL midrst_outputs: got %h want 0", {out, rise, fall, evt_sticky}); end
    n_vec++; if ({snap_valid, snap_data} !== 9'h000) begin n_err++; $display("FAIL midrst_snap: got %h want 000", {snap_valid, snap_data}); end
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    n_vec++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_snap: got %b want 0", snap_valid); end
    n_vec++; if (out !== 8'hC3) begin n_err++; $display("FAIL midrst_refilter: got %h want c3", out); end
  endtask

  task automatic test_stable1();
    exp_t e;
    in_raw1 = 8'h10;
    for (int k = 1; k <= 4; k++)
      exp1_q.push_back('{out: (k >= 3) ? 8'h10 : 8'h00, rise: (k == 3) ? 8'h10 : 8'h00, fall: 8'h00});
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = exp1_q.pop_front();
      n_vec++; if ({out1, rise1, fall1} !== e) begin n_err++; $display("FAIL stable1_rise edge %0d: got %h want %h", k, {out1, rise1, fall1}, e); end
    end
    in_raw1 = 8'h00;
    for (int k = 1; k <= 4; k++)
      exp1_q.push_back('{out: (k >= 3) ? 8'h00 : 8'h10, rise: 8'h00, fall: (k == 3) ? 8'h10 : 8'h00});
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = exp1_q.pop_front();
      n_vec++; if ({out1, rise1, fall1} !== e) begin n_err++; $display("FAIL stable1_fall edge %0d: got %h want %h", k, {out1, rise1, fall1}, e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    in_raw     = 8'h00;
    evt_clr    = 8'h00;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    in_raw1    = 8'h00;
    evt_clr1   = 8'h00;
    snap_req1  = 1'b0;
    snap_ready1 = 1'b0;
    test_reset();
    test_rise();
    test_glitch();
    test_sticky_clr();
    test_snapshot();
    test_back_to_back();
    test_glitch_sat();
    test_reset_mid();
    test_stable1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
